// File: rtl/brc_pipe.sv
// brc_pipe: pipelined RV32I branch resolution unit with statistics counters.
// Evaluates all six branch conditions from a single subtract, compares the
// result against the front-end prediction, and reports through a 1- or
// 2-stage valid-qualified pipeline with stall and flush.
module brc_pipe #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [WIDTH-1:0]   i_rs1_data,
  input  logic [WIDTH-1:0]   i_rs2_data,
  input  logic [2:0]         i_funct3,
  input  logic               i_pred_taken,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_cnt_clr,
  output logic               o_valid,
  output logic               o_br_less,
  output logic               o_br_equal,
  output logic               o_taken,
  output logic               o_mispredict,
  output logic               o_illegal,
  output logic [COUNT_W-1:0] o_br_cnt,
  output logic [COUNT_W-1:0] o_miss_cnt
);

  // Operands of the final compare, as presented to the output stage.
  logic       fin_valid;
  logic [2:0] fin_f3;
  logic       fin_pred;
  logic       fin_c;
  logic       fin_dmsb;
  logic       fin_amsb;
  logic       fin_bmsb;
  logic       fin_zero;

  generate
    if (LATENCY == 2) begin : g_two
      localparam int unsigned H = WIDTH / 2;

      logic [H:0]   lo_sum;
      logic [H:0]   hi_sum;
      logic         s1_valid_q, s1_valid_d;
      logic [H-1:0] s1_rs1_hi_q, s1_rs2_hi_q;
      logic [2:0]   s1_f3_q;
      logic         s1_pred_q, s1_carry_q, s1_lo_zero_q;

      // Low half of rs1 - rs2; its carry-out feeds the upper half next cycle.
      always_comb begin
        lo_sum = {1'b0, i_rs1_data[H-1:0]} + {1'b0, ~i_rs2_data[H-1:0]} + (H+1)'(1);
      end

      // Stage-1 valid: flush kills, stall holds, otherwise accept the input.
      always_comb begin
        s1_valid_d = i_valid;
        if (i_flush)      s1_valid_d = 1'b0;
        else if (i_stall) s1_valid_d = s1_valid_q;
      end

      // Stage-1 valid register.
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) s1_valid_q <= 1'b0;
        else         s1_valid_q <= s1_valid_d;
      end

      // Stage-1 data registers load only with an accepted valid branch.
      always_ff @(posedge i_clk) begin
        if (!i_flush && !i_stall && i_valid) begin
          s1_rs1_hi_q  <= i_rs1_data[WIDTH-1:H];
          s1_rs2_hi_q  <= i_rs2_data[WIDTH-1:H];
          s1_f3_q      <= i_funct3;
          s1_pred_q    <= i_pred_taken;
          s1_carry_q   <= lo_sum[H];
          s1_lo_zero_q <= (lo_sum[H-1:0] == '0);
        end
      end

      // Upper half completes the subtract using the registered mid carry.
      always_comb begin
        hi_sum    = {1'b0, s1_rs1_hi_q} + {1'b0, ~s1_rs2_hi_q} + (H+1)'(s1_carry_q);
        fin_valid = s1_valid_q;
        fin_f3    = s1_f3_q;
        fin_pred  = s1_pred_q;
        fin_c     = hi_sum[H];
        fin_dmsb  = hi_sum[H-1];
        fin_amsb  = s1_rs1_hi_q[H-1];
        fin_bmsb  = s1_rs2_hi_q[H-1];
        fin_zero  = s1_lo_zero_q & (hi_sum[H-1:0] == '0);
      end
    end else begin : g_one
      logic [WIDTH:0] sum;

      // Full-width subtract straight from the inputs.
      always_comb begin
        sum       = {1'b0, i_rs1_data} + {1'b0, ~i_rs2_data} + (WIDTH+1)'(1);
        fin_valid = i_valid;
        fin_f3    = i_funct3;
        fin_pred  = i_pred_taken;
        fin_c     = sum[WIDTH];
        fin_dmsb  = sum[WIDTH-1];
        fin_amsb  = i_rs1_data[WIDTH-1];
        fin_bmsb  = i_rs2_data[WIDTH-1];
        fin_zero  = (sum[WIDTH-1:0] == '0);
      end
    end
  endgenerate

  logic fin_ovf, fin_less, fin_illegal, fin_taken, fin_misp, out_load;

  // Condition decode from zero/carry/overflow flags.
  always_comb begin
    fin_ovf     = (fin_amsb != fin_bmsb) & (fin_dmsb != fin_amsb);
    fin_less    = fin_f3[1] ? ~fin_c : (fin_dmsb ^ fin_ovf);
    fin_illegal = (fin_f3[2:1] == 2'b01);
    unique case (fin_f3)
      3'b000:         fin_taken = fin_zero;
      3'b001:         fin_taken = ~fin_zero;
      3'b100, 3'b110: fin_taken = fin_less;
      3'b101, 3'b111: fin_taken = ~fin_less;
      default:        fin_taken = 1'b0;
    endcase
    fin_misp = ~fin_illegal & (fin_taken != fin_pred);
    out_load = ~i_flush & ~i_stall & fin_valid;
  end

  logic               valid_q, valid_d;
  logic               less_q, equal_q, taken_q, misp_q, illegal_q;
  logic [COUNT_W-1:0] br_cnt_q, br_cnt_d, miss_cnt_q, miss_cnt_d;

  // Output valid and saturating counters next-state; clear beats increment.
  always_comb begin
    valid_d = fin_valid;
    if (i_flush)      valid_d = 1'b0;
    else if (i_stall) valid_d = valid_q;

    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (i_cnt_clr) begin
      br_cnt_d   = '0;
      miss_cnt_d = '0;
    end else if (out_load) begin
      if (br_cnt_q != '1)              br_cnt_d   = br_cnt_q + COUNT_W'(1);
      if (fin_misp && miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + COUNT_W'(1);
    end
  end

  // Output register bank and counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      valid_q    <= 1'b0;
      less_q     <= 1'b0;
      equal_q    <= 1'b0;
      taken_q    <= 1'b0;
      misp_q     <= 1'b0;
      illegal_q  <= 1'b0;
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      valid_q    <= valid_d;
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      if (out_load) begin
        less_q    <= fin_less;
        equal_q   <= fin_zero;
        taken_q   <= fin_taken;
        misp_q    <= fin_misp;
        illegal_q <= fin_illegal;
      end
    end
  end

  assign o_valid      = valid_q;
  assign o_br_less    = less_q;
  assign o_br_equal   = equal_q;
  assign o_taken      = taken_q;
  assign o_mispredict = valid_q & misp_q;
  assign o_illegal    = illegal_q;
  assign o_br_cnt     = br_cnt_q;
  assign o_miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_brc_pipe.sv
// Scoreboard bench for brc_pipe: a LATENCY=2/COUNT_W=4 instance and a
// LATENCY=1/COUNT_W=16 instance share one randomized stimulus stream.
module tb_brc_pipe;

  typedef struct {
    logic        less, equal, taken, misp, illegal;
    int unsigned due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, vld, stall, flush, clr, pred;
  logic [31:0] rs1, rs2;
  logic [2:0]  f3;

  logic        a_valid, a_less, a_equal, a_taken, a_misp, a_ill;
  logic [3:0]  a_br, a_miss;
  logic        b_valid, b_less, b_equal, b_taken, b_misp, b_ill;
  logic [15:0] b_br, b_miss;

  exp_t        qa[$];
  exp_t        qb[$];
  int unsigned adv_cnt = 0;
  bit          last_adv = 1'b0, last_flush = 1'b0, last_clr = 1'b0;
  int          tests = 0;
  int          fails = 0;
  int unsigned mbr[2], mmiss[2];
  bit          prevv[2];

  brc_pipe #(.WIDTH(32), .LATENCY(2), .COUNT_W(4)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_valid(vld), .i_rs1_data(rs1), .i_rs2_data(rs2),
    .i_funct3(f3), .i_pred_taken(pred), .i_stall(stall), .i_flush(flush), .i_cnt_clr(clr),
    .o_valid(a_valid), .o_br_less(a_less), .o_br_equal(a_equal), .o_taken(a_taken),
    .o_mispredict(a_misp), .o_illegal(a_ill), .o_br_cnt(a_br), .o_miss_cnt(a_miss));

  brc_pipe #(.WIDTH(32), .LATENCY(1), .COUNT_W(16)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_valid(vld), .i_rs1_data(rs1), .i_rs2_data(rs2),
    .i_funct3(f3), .i_pred_taken(pred), .i_stall(stall), .i_flush(flush), .i_cnt_clr(clr),
    .o_valid(b_valid), .o_br_less(b_less), .o_br_equal(b_equal), .o_taken(b_taken),
    .o_mispredict(b_misp), .o_illegal(b_ill), .o_br_cnt(b_br), .o_miss_cnt(b_miss));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: branch semantics from plain integer comparisons.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] f, input logic p, input int unsigned due);
    exp_t e;
    e.equal   = (a == b);
    e.less    = f[1] ? (a < b) : ($signed(a) < $signed(b));
    e.illegal = (f == 3'b010) || (f == 3'b011);
    case (f)
      3'b000:         e.taken = e.equal;
      3'b001:         e.taken = !e.equal;
      3'b100, 3'b110: e.taken = e.less;
      3'b101, 3'b111: e.taken = !e.less;
      default:        e.taken = 1'b0;
    endcase
    e.misp = !e.illegal && (e.taken != p);
    e.due  = due;
    return e;
  endfunction

  // Monitor for one instance: pop the expected result when due, check counters.
  task automatic mon(input int id, input logic v, input logic [4:0] flags,
                     input int unsigned br, input int unsigned miss, input int unsigned cmax);
    exp_t e;
    bit   got = 1'b0;
    string nm = (id == 0) ? "a" : "b";
    if (id == 0) begin
      while (qa.size() > 0 && qa[0].due < adv_cnt) begin
        check({nm, "_missing_due"}, 64'(qa[0].due), 64'(adv_cnt));
        void'(qa.pop_front());
      end
      if (last_adv && !last_flush && qa.size() > 0 && qa[0].due == adv_cnt) begin
        e = qa.pop_front(); got = 1'b1;
      end
    end else begin
      while (qb.size() > 0 && qb[0].due < adv_cnt) begin
        check({nm, "_missing_due"}, 64'(qb[0].due), 64'(adv_cnt));
        void'(qb.pop_front());
      end
      if (last_adv && !last_flush && qb.size() > 0 && qb[0].due == adv_cnt) begin
        e = qb.pop_front(); got = 1'b1;
      end
    end
    if (got) begin
      check({nm, "_result{v,lt,eq,tk,mp,il}"}, 64'({v, flags}),
            64'({1'b1, e.less, e.equal, e.taken, e.misp, e.illegal}));
      if (!last_clr) begin
        if (mbr[id] < cmax) mbr[id]++;
        if (e.misp && mmiss[id] < cmax) mmiss[id]++;
      end
    end else if (last_flush) begin
      check({nm, "_flush_kill"}, 64'(v), 64'(0));
    end else if (last_adv) begin
      check({nm, "_no_spurious"}, 64'(v), 64'(0));
    end else begin
      check({nm, "_stall_hold"}, 64'(v), 64'(prevv[id]));
    end
    if (last_clr) begin
      mbr[id] = 0; mmiss[id] = 0;
    end
    check({nm, "_counters{br,miss}"}, {32'(br), 32'(miss)}, {32'(mbr[id]), 32'(mmiss[id])});
    prevv[id] = v;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      qa.delete(); qb.delete();
      mbr[0] = 0; mbr[1] = 0; mmiss[0] = 0; mmiss[1] = 0;
      prevv[0] = 1'b0; prevv[1] = 1'b0;
    end else begin
      mon(0, a_valid, {a_less, a_equal, a_taken, a_misp, a_ill}, 32'(a_br), 32'(a_miss), 15);
      mon(1, b_valid, {b_less, b_equal, b_taken, b_misp, b_ill}, 32'(b_br), 32'(b_miss), 65535);
    end
  end

  // One clock edge plus scoreboard bookkeeping for the inputs sampled there.
  task automatic tick();
    @(posedge clk);
    last_flush = flush;
    last_clr   = clr;
    last_adv   = flush || !stall;
    if (last_adv) adv_cnt++;
    if (flush) begin
      qa.delete(); qb.delete();
    end else if (!rst && !stall && vld) begin
      qa.push_back(model(rs1, rs2, f3, pred, adv_cnt + 1));
      qb.push_back(model(rs1, rs2, f3, pred, adv_cnt));
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f, input logic p,
                       input logic st, input logic fl, input logic cl);
    vld = v; rs1 = a; rs2 = b; f3 = f; pred = p; stall = st; flush = fl; clr = cl;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, 64'({a_valid, a_less, a_equal, a_taken, a_misp, a_ill, a_br, a_miss}), 64'(0));
    check({tag, "_b"}, 64'({b_valid, b_less, b_equal, b_taken, b_misp, b_ill, b_br, b_miss}), 64'(0));
  endtask

  initial begin
    logic [31:0] r1, r2;
    rst = 1'b1; vld = 1'b0; stall = 1'b0; flush = 1'b0; clr = 1'b0; pred = 1'b0;
    rs1 = '0; rs2 = '0; f3 = '0;
    #3;
    check_all_zero("reset_state");
    tick(); tick();
    rst = 1'b0;
    idle(2);

    // Directed compares: signed vs unsigned, signed overflow, mispredict, illegal.
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h8000_0000, 32'h0000_0001, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_1234, 32'h0000_1234, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_0005, 32'h0000_0007, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Back-to-back branches, then a 3-cycle stall with ignored inputs.
    for (int i = 0; i < 3; i++)
      drive(1'b1, pick(), pick(), 3'($urandom % 8), 1'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      drive(1'b1, pick(), pick(), 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Two in flight, then flush together with stall.
    for (int i = 0; i < 2; i++)
      drive(1'b1, pick(), pick(), 3'($urandom % 8), 1'($urandom), 1'b0, 1'b0, 1'b0);
    drive(1'b1, pick(), pick(), 3'b001, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(3);

    // Saturation of the 4-bit counters.
    for (int i = 0; i < 17; i++)
      drive(1'b1, pick(), pick(), 3'($urandom % 8), 1'($urandom), 1'b0, 1'b0, 1'b0);
    idle(2);
    check("sat_a_br", 64'(a_br), 64'(15));

    // Clear coinciding with the output load of the latency-2 instance.
    drive(1'b1, 32'h1, 32'h2, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_a", 64'({a_valid, a_br, a_miss}), 64'({1'b1, 4'd0, 4'd0}));
    check("clr_b", 64'({b_br, b_miss}), 64'(0));
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic st;
      r1 = pick();
      r2 = ($urandom % 4 == 0) ? r1 : pick();
      st = ($urandom % 7 == 0);
      drive(1'($urandom % 4 != 0), r1, r2, 3'($urandom % 8), 1'($urandom),
            st, 1'($urandom % 20 == 0), 1'(!st && ($urandom % 25 == 0)));
    end
    idle(4);
    check("drain_a", 64'(qa.size()), 64'(0));
    check("drain_b", 64'(qb.size()), 64'(0));

    // Reset while a branch sits in stage 1 of the latency-2 instance.
    drive(1'b1, 32'h10, 32'h10, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    vld = 1'b0;
    #2 rst = 1'b1;
    #1 check_all_zero("reset_midop");
    tick(); tick();
    rst = 1'b0;
    idle(5);
    check("post_reset_a_valid", 64'(a_valid), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
